window_3x3_gen: RTL
===================

# window_3x3_gen

Raster-to-window stage feeding the 3x3 Gaussian smoothing stage. It accepts one 8-bit pixel per cycle in raster order over a valid/ready handshake and buffers two image lines. It emits one 3x3 neighbourhood per pixel centre, in raster order, with border taps padded. Its `win_valid`/`win` outputs drive the smoothing stage's enable and 3x3 input directly.

## Interface
- `ROWS`, 512, image height in pixels; must be at least 2.
- `COLS`, 512, image width in pixels; must be at least 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless the state is IDLE.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  the block accepts a pixel this cycle.
- `pix_in`  in  8  input pixel, raster order.
- `win_valid`  out  1  `win`, `win_row` and `win_col` are valid.
- `win_ready`  in  1  the downstream stage consumes the window this cycle.
- `win[3][3]`  out  8 each  neighbourhood; `[1][1]` is the centre, `[0][*]` is the row above, `[*][0]` is the column left.
- `win_row`  out  $clog2(ROWS)  centre row of `win`.
- `win_col`  out  $clog2(COLS)  centre column of `win`.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last window of a frame is accepted.

## Operation
- Storage:
  - Two line buffers of `COLS` x 8 bits each.
  - A 3x3 register array of taps.
  - Input pixel counter `in_cnt` covering 0..ROWS*COLS-1.
  - Output centre counters `win_row` and `win_col`.
- States:
  - IDLE: `start` moves to FILL and clears the counters.
  - FILL: accepts pixels with no output. Once pixel index COLS+1 (the pixel at row 1, column 1) is accepted, moves to RUN.
  - RUN: each accepted pixel produces one window.
  - FLUSH: entered when pixel index ROWS*COLS-1 is accepted. Injects COLS+1 virtual zero pixels internally; `pix_ready` is 0.
  - DONE: reached when the window at (ROWS-1, COLS-1) is accepted. `frame_done` pulses for one cycle, then the state returns to IDLE.
- Window rule: the window centred at raster index k becomes valid after input index k+COLS+1 is accepted, or after the equivalent flush step.
- Padding: any tap whose row is outside 0..ROWS-1 or whose column is outside 0..COLS-1 is forced to 0.
- Column wrap: at `win_col`=COLS-1 the next centre is column 0 of the next row. Taps must not leak pixels from the previous or next line.
- Output register: one-deep.
  - `pix_ready` = (state is FILL or RUN) and (`win_valid` is 0 or `win_ready` is 1).
  - While `win_valid`=1 and `win_ready`=0, `win`, `win_row` and `win_col` hold stable.
- No arithmetic is performed; pixel values pass through unmodified.
- Reset mid-frame: all state is discarded immediately and the block returns to IDLE. No `frame_done` is issued.

## Timing
- Reset values:
  - `pix_ready`, `win_valid`, `busy` and `frame_done` are 0.
  - `win` is all zeros; `win_row` and `win_col` are 0.
  - State is IDLE.
- `start` at edge t makes `busy`=1 and `pix_ready`=1 at t+1.
- `win_valid` rises on the edge after pixel index COLS+1 is accepted. Latency is COLS+2 accepted pixels plus one cycle.
- Throughput is one window per cycle when `pix_valid`=1 and `win_ready`=1. A frame takes ROWS*COLS+1 accepted inputs-equivalent cycles plus COLS+1 flush cycles.
- In FLUSH, a window is emitted every cycle that `win_ready`=1.
- `frame_done` asserts on the edge after the final window handshake. `busy` falls on the same edge.
- `start` and `pix_valid` in the same cycle: the pixel is not accepted in that cycle.

## Configuration
- `WINGEN_BORDER_REPLICATE_EN`
  - Defined: out-of-range taps take the nearest in-range pixel (coordinate clamp) instead of 0.
  - Undefined: zero padding as described under Operation.

## Test plan
All scenarios use ROWS=4, COLS=4 and `pix_in` = raster index + 1 (values 1..16), unless stated otherwise.

- Continuous stream, `win_ready`=1:
  - First `win_valid` follows acceptance of the sixth pixel, with `win` = {0,0,0},{0,1,2},{0,5,6}.
  - Exactly 16 windows are emitted, and `frame_done` pulses once.
- Last window (3,3) -> `win` = {11,12,0},{15,16,0},{0,0,0}.
- Window (1,3) -> {3,4,0},{7,8,0},{11,12,0}. Window (2,0) -> {0,5,6},{0,9,10},{0,13,14}; no wrap leakage.
- Random `win_ready` and `pix_valid` stalls:
  - The window sequence is identical to the no-stall run.
  - Outputs hold stable while `win_valid`=1 and `win_ready`=0.
  - No pixel is lost or duplicated.
- With `WINGEN_BORDER_REPLICATE_EN` defined:
  - Window (0,0) = {1,1,2},{1,1,2},{5,5,6}.
  - Window (3,3) = {11,12,12},{15,16,16},{15,16,16}.
- Reset asserted mid-RUN after 8 pixels:
  - All outputs return to their reset values immediately.
  - A following `start` plus a full frame reproduces the first scenario exactly.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window_3x3_gen.
interface window_3x3_gen_if #(
  parameter int ROWS = 512,
  parameter int COLS = 512
);
  logic                         pix_valid;
  logic                         pix_ready;
  logic [7:0]                   pix_in;
  logic                         win_valid;
  logic                         win_ready;
  logic [0:2][0:2][7:0]         win;
  logic [$clog2(ROWS)-1:0]      win_row;
  logic [$clog2(COLS)-1:0]      win_col;

  modport master (
    output pix_valid, pix_in, win_ready,
    input  pix_ready, win_valid, win, win_row, win_col
  );

  modport slave (
    input  pix_valid, pix_in, win_ready,
    output pix_ready, win_valid, win, win_row, win_col
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster-to-3x3-window generator with two line buffers and border padding.
// Define WINGEN_BORDER_REPLICATE_EN to clamp border taps instead of zeroing them.
module window_3x3_gen #(
  parameter int ROWS = 512,
  parameter int COLS = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  window_3x3_gen_if.slave   bus
);
  localparam int NPIX = ROWS * COLS;
  localparam int CW   = $clog2(NPIX + COLS + 2);
  localparam int RW   = $clog2(ROWS);
  localparam int CLW  = $clog2(COLS);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
  state_t state, nxt;

  logic [7:0]           lb0 [COLS];
  logic [7:0]           lb1 [COLS];
  logic [0:2][0:2][7:0] taps, nt, wv;
  logic [CW-1:0]        in_cnt;
  logic [CLW-1:0]       in_col, out_c;
  logic [RW-1:0]        out_r;
  logic [7:0]           pix;
  logic                 acc, step, emit, last_in, flush_end;
  logic                 top, bot, left, right;

  assign last_in   = in_cnt == CW'(NPIX - 1);
  assign flush_end = in_cnt == CW'(NPIX + COLS + 1);

  assign bus.pix_ready = (state == FILL || state == RUN) && (!bus.win_valid || bus.win_ready);
  assign acc  = bus.pix_valid && bus.pix_ready;
  // flush steps push virtual zero pixels while the output slot is free
  assign step = acc || (state == FLUSH && !flush_end && (!bus.win_valid || bus.win_ready));
  assign emit = step && in_cnt >= CW'(COLS + 1);

  // frame_done and the falling edge of busy coincide, so DONE is not busy
  assign busy       = state == FILL || state == RUN || state == FLUSH;
  assign frame_done = state == DONE;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = FILL;
      FILL:  if (acc && last_in) nxt = FLUSH;
             else if (acc && in_cnt == CW'(COLS + 1)) nxt = RUN;
      RUN:   if (acc && last_in) nxt = FLUSH;
      FLUSH: if (flush_end && bus.win_valid && bus.win_ready) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign pix   = (state == FLUSH) ? 8'd0 : bus.pix_in;
  assign top   = out_r == '0;
  assign bot   = out_r == RW'(ROWS - 1);
  assign left  = out_c == '0;
  assign right = out_c == CLW'(COLS - 1);

  // new right-hand column: two lines up, one line up, incoming pixel
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nt[i][0] = taps[i][1];
      nt[i][1] = taps[i][2];
    end
    nt[0][2] = lb1[in_col];
    nt[1][2] = lb0[in_col];
    nt[2][2] = pix;
  end

  // Border taps hold stale or wrapped data; the centre is always in range.
  always_comb begin
    wv = nt;
`ifdef WINGEN_BORDER_REPLICATE_EN
    for (int i = 0; i < 3; i++) begin
      if (left)  wv[i][0] = nt[i][1];
      if (right) wv[i][2] = nt[i][1];
    end
    if (top) wv[0] = wv[1];
    if (bot) wv[2] = wv[1];
`else
    for (int i = 0; i < 3; i++) begin
      if (left)  wv[i][0] = 8'd0;
      if (right) wv[i][2] = 8'd0;
    end
    if (top) wv[0] = '0;
    if (bot) wv[2] = '0;
`endif
  end

  // Line buffer contents never reach the output unmasked, so no reset needed.
  always_ff @(posedge clk)
    if (step) begin
      lb1[in_col] <= lb0[in_col];
      lb0[in_col] <= pix;
    end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps          <= '0;
      in_cnt        <= '0;
      in_col        <= '0;
      out_r         <= '0;
      out_c         <= '0;
      bus.win_valid <= 1'b0;
      bus.win       <= '0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
    end else begin
      if (state == IDLE && start) begin
        in_cnt <= '0;
        in_col <= '0;
        out_r  <= '0;
        out_c  <= '0;
      end
      if (step) begin
        taps   <= nt;
        in_cnt <= in_cnt + CW'(1);
        in_col <= (in_col == CLW'(COLS - 1)) ? '0 : in_col + CLW'(1);
      end
      if (emit) begin
        bus.win_valid <= 1'b1;
        bus.win       <= wv;
        bus.win_row   <= out_r;
        bus.win_col   <= out_c;
        if (right) begin
          out_c <= '0;
          out_r <= out_r + RW'(1);
        end else begin
          out_c <= out_c + CLW'(1);
        end
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end
    end
  end
endmodule
